// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_CLKS_PER_BIT = 10416;
  localparam int UART_CNT_W        = 14;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam logic [UART_CNT_W-1:0] LAST = UART_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_CNT_W-1:0] ONE  = UART_CNT_W'(1);

  logic [UART_CNT_W-1:0] baud_cnt;

  assign bit_end = (baud_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
    end else if (clear || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a one-byte holding buffer; back-to-back frames
// leave no idle gap on the line.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (line low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); pulls the next byte straight into START
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  tx_state_t  state, state_n;
  logic [7:0] buf_data;
  logic       buf_valid;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic       tx_n;
  logic       pull;
  logic       bit_end;

  // Held clear in IDLE, so every frame's start bit begins from zero.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .bit_end(bit_end)
  );

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    pull      = 1'b0;
    tx_done   = 1'b0;
    case (state)
      IDLE: begin
        if (buf_valid) begin
          pull    = 1'b1;
          shreg_n = buf_data;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_n   = shreg >> 1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        tx_done = bit_end;
        if (bit_end) begin
          if (buf_valid) begin
            pull    = 1'b1;
            shreg_n = buf_data;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is derived from the next state so tx can be a plain flop.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
    end
  end

  // A write needs an empty buffer and a pull needs a full one, so they never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_data  <= '0;
      buf_valid <= 1'b0;
    end else if (pull) begin
      buf_valid <= 1'b0;
    end else if (tx_start && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= tx_data;
    end
  end

  assign tx_ready = !buf_valid;
  assign tx_busy  = (state != IDLE) || buf_valid;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a frame-level model predicts accepted bytes and
// frame start cycles; a line monitor decodes frames and checks them.
module tb_uart_tx;

  localparam int N      = 4;
  localparam int FRAME  = 10 * N;
  localparam int SLOW_N = 10416;

  logic clk = 1'b0;
  always #5 clk = ~clk;   // 10 time units = one 100 MHz period

  logic       reset, tx_start, tx_ready, tx_busy, tx_done, tx;
  logic [7:0] tx_data;
  logic       s_reset, s_start, s_ready, s_busy, s_done, s_tx;
  logic [7:0] s_data;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
  );

  uart_tx dut_slow (
    .clk(clk), .reset(s_reset), .tx_data(s_data), .tx_start(s_start),
    .tx_ready(s_ready), .tx_busy(s_busy), .tx_done(s_done), .tx(s_tx)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: one-byte buffer in front of a line busy for FRAME cycles.
  int         cyc    = 0;
  bit         m_buf  = 1'b0;
  int         m_left = 0;
  logic [7:0] exp_bytes[$];
  int         exp_starts[$];

  initial forever begin
    bit old_buf;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      m_buf  = 1'b0;
      m_left = 0;
      exp_bytes.delete();
      exp_starts.delete();
    end else begin
      old_buf = m_buf;
      if (m_buf && m_left <= 1) begin
        m_buf  = 1'b0;
        m_left = FRAME;
        exp_starts.push_back(cyc);
      end else if (m_left > 0) begin
        m_left--;
      end
      if (tx_start && !old_buf) begin
        m_buf = 1'b1;
        exp_bytes.push_back(tx_data);
      end
    end
  end

  // Line monitor.
  bit         in_frame   = 1'b0;
  int         idx        = 0;
  logic       samples[FRAME];
  int         frames_seen = 0;
  int         done_seen   = 0;
  logic [7:0] seen[$];
  int         seen_starts[$];

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      in_frame = 1'b0;
      check("rst_tx", tx, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
    end else begin
      check("tx_ready", tx_ready, !m_buf);
      check("tx_busy", tx_busy, (m_buf || m_left > 0));
      if (!in_frame) begin
        if (tx == 1'b0) begin
          in_frame = 1'b1;
          idx      = 0;
          samples[0] = tx;
          seen_starts.push_back(cyc);
          if (exp_starts.size() == 0) fail_now("unexpected_start");
          else check("start_cycle", cyc, exp_starts.pop_front());
        end
      end else begin
        idx++;
        samples[idx] = tx;
      end
      check("tx_done", tx_done, (in_frame && idx == FRAME - 1));
      if (tx_done) done_seen++;
      if (in_frame && idx == FRAME - 1) begin
        logic [7:0] b;
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 10; i++)
          for (int j = 1; j < N; j++)
            if (samples[i*N + j] !== samples[i*N]) ok = 1'b0;
        check("bit_hold", ok, 1);
        check("start_bit", samples[0], 0);
        check("stop_bit", samples[9*N], 1);
        for (int i = 0; i < 8; i++) b[i] = samples[(i+1)*N];
        if (exp_bytes.size() == 0) fail_now("unexpected_frame");
        else check("byte", b, exp_bytes.pop_front());
        seen.push_back(b);
        frames_seen++;
        in_frame = 1'b0;
      end
    end
  end

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!tx_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) fail_now("timeout_ready");
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_buf || m_left > 0 || in_frame || exp_bytes.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("timeout_idle");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_slow_tx(input logic level, input int budget, output longint t);
    int n = 0;
    while (s_tx !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (s_tx !== level) fail_now("timeout_slow_tx");
    t = $time;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     f0, d0, c0, n;
    longint t0, t1, t2;
    int     cy0, cy1;

    tx_start = 1'b0; tx_data = 8'h00;
    s_start  = 1'b0; s_data  = 8'h00;
    reset = 1'b1; s_reset = 1'b1;
    #1;
    reset = 1'b0; s_reset = 1'b0;

    // Reset held: writes must have no effect.
    repeat (6) begin
      @(negedge clk);
      tx_start = ~tx_start;
      tx_data  = 8'($urandom);
    end
    @(negedge clk);
    tx_start = 1'b0;
    check("reset_tx", tx, 1);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_no_done", done_seen, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5.
    f0 = frames_seen; d0 = done_seen;
    write_byte(8'hA5);
    wait_idle(200);
    check("a5_frames", frames_seen - f0, 1);
    check("a5_done", done_seen - d0, 1);
    if (seen.size() > 0) check("a5_byte", seen[$], 8'hA5);

    // Back-to-back 0x08 then 0xFF.
    f0 = frames_seen; d0 = done_seen;
    write_byte(8'h08);
    wait_ready(20);
    write_byte(8'hFF);
    wait_idle(300);
    check("b2b_frames", frames_seen - f0, 2);
    check("b2b_done", done_seen - d0, 2);
    if (seen.size() >= 2) begin
      check("b2b_first", seen[$-1], 8'h08);
      check("b2b_second", seen[$], 8'hFF);
      check("b2b_gap", seen_starts[$] - seen_starts[$-1], FRAME);
    end

    // Overflow: third write while the buffer is full is dropped.
    f0 = frames_seen;
    write_byte(8'h01);
    wait_ready(20);
    write_byte(8'h02);
    check("ovf_ready_low", tx_ready, 0);
    tx_start = 1'b1;
    tx_data  = 8'h03;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle(300);
    check("ovf_frames", frames_seen - f0, 2);
    if (seen.size() >= 2) begin
      check("ovf_first", seen[$-1], 8'h01);
      check("ovf_second", seen[$], 8'h02);
    end

    // Reset during data bit 3 with a byte buffered.
    write_byte(8'h00);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) fail_now("timeout_fall");
    c0 = cyc;
    write_byte(8'h7E);
    n = 0;
    while (cyc < c0 + 17 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_pre_tx", tx, 0);
    check("mid_pre_ready", tx_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("mid_tx_async", tx, 1);
    check("mid_ready_async", tx_ready, 1);
    check("mid_busy_async", tx_busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    f0 = frames_seen;
    repeat (60) @(negedge clk);
    check("mid_no_frame", frames_seen - f0, 0);
    check("mid_ready_after", tx_ready, 1);
    check("mid_busy_after", tx_busy, 0);

    // Randomized traffic.
    repeat (3000) begin
      @(negedge clk);
      tx_start = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
    end
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle(4 * FRAME);
    check("rand_queue_empty", exp_bytes.size(), 0);

    // Default-rate instance: start bit and data bit 0 of 0x55.
    @(negedge clk);
    s_reset = 1'b1;
    @(negedge clk);
    s_start = 1'b1;
    s_data  = 8'h55;
    @(negedge clk);
    s_start = 1'b0;
    wait_slow_tx(1'b0, 10, t0);
    cy0 = cyc;
    wait_slow_tx(1'b1, SLOW_N + 10, t1);
    cy1 = cyc;
    check("slow_start_ns", t1 - t0, 10 * SLOW_N);
    check("slow_start_cycles", cy1 - cy0, SLOW_N);
    wait_slow_tx(1'b0, SLOW_N + 10, t2);
    check("slow_bit0_ns", t2 - t1, 10 * SLOW_N);
    s_reset = 1'b0;
    #1;
    check("slow_reset_tx", s_tx, 1);
    check("slow_reset_ready", s_ready, 1);
    check("slow_reset_busy", s_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
